// File: rtl/cpu_regfile_debug_access_if.sv
// Command/response channels between the debug transport (master) and the
// register-file debug initiator (slave).
interface cpu_regfile_debug_access_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_addr;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err
  );
endinterface

// File: rtl/cpu_regfile_debug_access.sv
// Debug initiator for the CPU register file: halts the core, performs READ/WRITE/DUMP
// through the register-file ports and returns one response per register touched.
module cpu_regfile_debug_access #(
  parameter int HALT_TIMEOUT = 255,
  parameter int DUMP_FIRST   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  cpu_regfile_debug_access_if.slave        bus,
  output logic                             halt_req,
  input  logic                             halt_ack,
  output logic                             rf_own,
  output logic [4:0]                       rf_a1,
  input  logic [31:0]                      rf_rd1,
  output logic [4:0]                       rf_a3,
  output logic [31:0]                      rf_wd3,
  output logic                             rf_we3
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT_WAIT,
    S_EXEC,
    S_RESP,
    S_RELEASE
  } state_e;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_DUMP    = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_e;

  localparam int             TW           = $clog2(HALT_TIMEOUT + 1);
  localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(HALT_TIMEOUT);
  localparam logic [4:0]     FIRST_IDX    = 5'(DUMP_FIRST);
  localparam logic [4:0]     LAST_IDX     = 5'd31;

  state_e        state;
  op_e           op;
  logic [4:0]    idx;
  logic [31:0]   data;
  logic [TW-1:0] tcnt;

  logic          cmd_ready;
  logic          rsp_valid;
  logic [4:0]    rsp_addr;
  logic [31:0]   rsp_data;
  logic          rsp_last;
  logic          rsp_err;

  logic [TW-1:0] tcnt_next;
  logic [4:0]    idx_next;

  assign tcnt_next = tcnt + TW'(1);
  assign idx_next  = idx + 5'd1;

  // NOTE: every register here is state, so it is written only with <= inside
  // the clocked block; blocking writes would race with readers at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op        <= OP_READ;
      idx       <= '0;
      data      <= '0;
      tcnt      <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
      halt_req  <= 1'b0;
      rf_own    <= 1'b0;
      rf_a1     <= '0;
      rf_a3     <= '0;
      rf_wd3    <= '0;
      rf_we3    <= 1'b0;
    end else begin
      // The write strobe is only ever raised on entry to EXEC, so it lasts one cycle.
      rf_we3 <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op        <= op_e'(bus.cmd_op);
            data      <= bus.cmd_data;
            tcnt      <= '0;
            if (op_e'(bus.cmd_op) == OP_ILLEGAL) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_last  <= 1'b1;
              rsp_data  <= '0;
              rsp_addr  <= bus.cmd_addr;
              state     <= S_RESP;
            end else begin
              idx      <= (op_e'(bus.cmd_op) == OP_DUMP) ? FIRST_IDX : bus.cmd_addr;
              halt_req <= 1'b1;
              state    <= S_HALT_WAIT;
            end
          end
        end

        S_HALT_WAIT: begin
          if (halt_ack) begin
            rf_own <= 1'b1;
            if (op == OP_WRITE) begin
              rf_a3  <= idx;
              rf_wd3 <= data;
              rf_we3 <= 1'b1;
            end else begin
              rf_a1 <= idx;
            end
            state <= S_EXEC;
          end else if (tcnt_next == TIMEOUT_LAST) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_last  <= 1'b1;
            rsp_data  <= '0;
            rsp_addr  <= idx;
            state     <= S_RESP;
          end else begin
            tcnt <= tcnt_next;
          end
        end

        S_EXEC: begin
          rf_own    <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_addr  <= idx;
          rsp_data  <= (op == OP_WRITE) ? data : rf_rd1;
          rsp_last  <= !((op == OP_DUMP) && (idx != LAST_IDX));
          state     <= S_RESP;
        end

        S_RESP: begin
          if (rsp_valid && bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            if ((op == OP_DUMP) && !rsp_last) begin
              idx    <= idx_next;
              rf_a1  <= idx_next;
              rf_own <= 1'b1;
              state  <= S_EXEC;
            end else if (rsp_err) begin
              // Errors never hand the ports over, so there is no ack to wait out.
              halt_req  <= 1'b0;
              cmd_ready <= 1'b1;
              state     <= S_IDLE;
            end else begin
              halt_req <= 1'b0;
              state    <= S_RELEASE;
            end
          end
        end

        S_RELEASE: begin
          if (!halt_ack) begin
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_addr  = rsp_addr;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_last  = rsp_last;
  assign bus.rsp_err   = rsp_err;

endmodule

// File: tb/tb_cpu_regfile_debug_access.sv
// Bench for cpu_regfile_debug_access: register-file and core environment, a
// transaction-level expected-response model, and randomized plus directed commands.
module tb_cpu_regfile_debug_access;
  localparam int HALT_TIMEOUT = 8;
  localparam int DUMP_FIRST   = 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
    logic        err;
  } rsp_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt_req, halt_ack, rf_own, rf_we3;
  logic [4:0]  rf_a1, rf_a3;
  logic [31:0] rf_rd1, rf_wd3;

  cpu_regfile_debug_access_if bus ();

  cpu_regfile_debug_access #(.HALT_TIMEOUT(HALT_TIMEOUT), .DUMP_FIRST(DUMP_FIRST)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .halt_req(halt_req), .halt_ack(halt_ack), .rf_own(rf_own),
    .rf_a1(rf_a1), .rf_rd1(rf_rd1), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we3(rf_we3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic rsp_t mk(input logic [4:0] a, input logic [31:0] d, input logic l, input logic e);
    rsp_t r;
    r.addr = a; r.data = d; r.last = l; r.err = e;
    return r;
  endfunction

  // Environment: register file (x0 hardwired to zero) and a halting core.
  logic [31:0] env_regs [32];
  assign rf_rd1 = env_regs[rf_a1];

  initial begin
    for (int i = 0; i < 32; i++) env_regs[i] = 32'(i * 4);
    forever begin
      @(posedge clk);
      if (rf_we3 && rf_a3 != 5'd0) env_regs[rf_a3] = rf_wd3;
    end
  end

  int ack_delay = 0;
  bit ack_never = 1'b0;
  int rel_delay = 0;

  initial begin
    int hcnt = 0;
    int relcnt = 0;
    halt_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (halt_req) begin
        relcnt = 0;
        if (!ack_never && hcnt >= ack_delay) halt_ack = 1'b1;
        hcnt++;
      end else begin
        hcnt = 0;
        if (halt_ack) begin
          if (relcnt >= rel_delay) begin halt_ack = 1'b0; relcnt = 0; end
          else relcnt++;
        end
      end
    end
  end

  int unsigned ready_pct = 100;
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.rsp_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  // Reference model: architectural register contents and expected transactions.
  logic [31:0] model_regs [32];
  rsp_t        exp_q [$];
  wr_t         wq [$];

  task automatic model_cmd(input logic [1:0] op, input logic [4:0] addr,
                           input logic [31:0] data, input bit never);
    wr_t w;
    if (op == 2'd3) begin
      exp_q.push_back(mk(addr, 32'd0, 1'b1, 1'b1));
    end else if (never) begin
      exp_q.push_back(mk((op == 2'd2) ? 5'(DUMP_FIRST) : addr, 32'd0, 1'b1, 1'b1));
    end else if (op == 2'd0) begin
      exp_q.push_back(mk(addr, model_regs[addr], 1'b1, 1'b0));
    end else if (op == 2'd1) begin
      exp_q.push_back(mk(addr, data, 1'b1, 1'b0));
      w.addr = addr; w.data = data;
      wq.push_back(w);
      if (addr != 5'd0) model_regs[addr] = data;
    end else begin
      for (int i = DUMP_FIRST; i < 32; i++)
        exp_q.push_back(mk(5'(i), model_regs[i], (i == 31), 1'b0));
    end
  endtask

  // Compare process: responses, write port and back-pressure stability each cycle.
  int   halt_cycles = 0, own_cycles = 0, we_pulses = 0, rsp_count = 0;
  int   first_rsp_cyc = -1, last_hs_cyc = 0;
  rsp_t last_rsp;

  initial begin
    rsp_t cur, held, e;
    wr_t  w;
    bit   hold = 1'b0, prev_we3 = 1'b0, prev_valid = 1'b0;
    last_rsp = '0;
    held = '0;
    forever begin
      @(negedge clk);
      if (halt_req) halt_cycles++;
      if (rf_own) own_cycles++;
      if (rst) begin hold = 1'b0; prev_we3 = 1'b0; prev_valid = 1'b0; continue; end
      if (rf_we3) begin
        we_pulses++;
        if (wq.size() == 0) check("write_unexpected", 128'(rf_we3), 128'(1'b0));
        else begin
          w = wq.pop_front();
          check("write_port", 128'({rf_own, prev_we3, rf_a3, rf_wd3}),
                128'({1'b1, 1'b0, w.addr, w.data}));
        end
      end
      prev_we3 = rf_we3;
      cur.addr = bus.rsp_addr; cur.data = bus.rsp_data;
      cur.last = bus.rsp_last; cur.err = bus.rsp_err;
      if (hold) check("rsp_stable", 128'({bus.rsp_valid, cur}), 128'({1'b1, held}));
      if (bus.rsp_valid && !prev_valid && first_rsp_cyc < 0) first_rsp_cyc = cyc;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 128'(bus.rsp_valid), 128'(1'b0));
        else begin
          e = exp_q.pop_front();
          check("rsp", 128'(cur), 128'(e));
          last_rsp = cur;
          rsp_count++;
          last_hs_cyc = cyc;
        end
      end
      hold = bus.rsp_valid && !bus.rsp_ready;
      held = cur;
      prev_valid = bus.rsp_valid;
    end
  end

  int accept_cyc = 0;

  task automatic check_reset(input string name);
    check(name, 128'({bus.cmd_ready, bus.rsp_valid, bus.rsp_last, bus.rsp_err, halt_req,
                      rf_own, rf_we3, bus.rsp_addr, bus.rsp_data, rf_a1, rf_a3, rf_wd3}),
          128'({1'b1, 6'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0}));
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] data,
                        input int delay, input bit never, input bit wait_done);
    bit accepted = 1'b0;
    bit done = 1'b0;
    for (int i = 0; i < 50 && halt_ack; i++) @(negedge clk);
    ack_delay = delay;
    ack_never = never;
    model_cmd(op, addr, data, never);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_data = data;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin accepted = 1'b1; break; end
    end
    accept_cyc = cyc; halt_cycles = 0; own_cycles = 0; first_rsp_cyc = -1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'($urandom); bus.cmd_addr = 5'($urandom); bus.cmd_data = $urandom;
    if (!accepted) begin
      check("cmd_accept", 128'(accepted), 128'(1'b1));
      exp_q.delete(); wq.delete();
      return;
    end
    if (wait_done) begin
      for (int i = 0; i < 3000; i++) begin
        @(negedge clk);
        if (exp_q.size() == 0 && wq.size() == 0 && bus.cmd_ready) begin done = 1'b1; break; end
      end
      if (!done) begin
        check("cmd_done_in_time", 128'(done), 128'(1'b1));
        exp_q.delete(); wq.delete();
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    int n0, p0, seen;
    logic [1:0] op;
    int r;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'(i * 4);
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_addr = 5'd0; bus.cmd_data = 32'd0;

    @(negedge clk);
    check_reset("reset_state");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // DUMP with random back-pressure: 31 responses, last one is x31 = 124.
    ready_pct = 60;
    n0 = rsp_count;
    do_cmd(2'd2, 5'd0, 32'd0, 1, 1'b0, 1'b1);
    check("dump_count", 128'(rsp_count - n0), 128'(31));
    check("dump_final", 128'(last_rsp), 128'(mk(5'd31, 32'd124, 1'b1, 1'b0)));

    // DUMP with rsp_ready held high: one response every 2 cycles.
    ready_pct = 100;
    do_cmd(2'd2, 5'd0, 32'd0, 0, 1'b0, 1'b1);
    check("dump_rate", 128'(last_hs_cyc - first_rsp_cyc), 128'(60));

    env_regs[5] = 32'hDEADBEEF;
    model_regs[5] = 32'hDEADBEEF;
    do_cmd(2'd0, 5'd5, 32'd0, 2, 1'b0, 1'b1);
    check("read_x5", 128'(last_rsp), 128'(mk(5'd5, 32'hDEADBEEF, 1'b1, 1'b0)));
    check("exec_one_cycle", 128'(own_cycles), 128'(1));

    do_cmd(2'd0, 5'd5, 32'd0, 0, 1'b0, 1'b1);
    check("read_latency", 128'(first_rsp_cyc - accept_cyc), 128'(3));

    p0 = we_pulses;
    do_cmd(2'd1, 5'd7, 32'h12345678, 1, 1'b0, 1'b1);
    check("write_pulse_count", 128'(we_pulses - p0), 128'(1));
    do_cmd(2'd0, 5'd7, 32'd0, 0, 1'b0, 1'b1);
    check("read_x7", 128'(last_rsp), 128'(mk(5'd7, 32'h12345678, 1'b1, 1'b0)));

    do_cmd(2'd1, 5'd0, 32'hFFFFFFFF, 0, 1'b0, 1'b1);
    do_cmd(2'd0, 5'd0, 32'd0, 0, 1'b0, 1'b1);
    check("read_x0", 128'(last_rsp), 128'(mk(5'd0, 32'd0, 1'b1, 1'b0)));

    do_cmd(2'd3, 5'd9, 32'd0, 0, 1'b0, 1'b1);
    check("illegal_rsp", 128'(last_rsp), 128'(mk(5'd9, 32'd0, 1'b1, 1'b1)));
    check("illegal_no_halt", 128'(halt_cycles), 128'(0));

    do_cmd(2'd0, 5'd3, 32'd0, 0, 1'b1, 1'b1);
    check("timeout_rsp", 128'(last_rsp), 128'(mk(5'd3, 32'd0, 1'b1, 1'b1)));
    check("timeout_latency", 128'(first_rsp_cyc - accept_cyc), 128'(HALT_TIMEOUT + 1));
    check("timeout_no_own", 128'(own_cycles), 128'(0));
    check("timeout_halt_dropped", 128'(halt_req), 128'(1'b0));

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 8) ? 2'd2 : (r < 9) ? 2'd3 : 2'd0;
      ready_pct = $urandom_range(20, 100);
      rel_delay = $urandom_range(0, 3);
      do_cmd(op, 5'($urandom), $urandom, $urandom_range(0, 6),
             ($urandom_range(0, 9) == 0), 1'b1);
    end

    // Reset in the middle of a DUMP while index 10 is being executed.
    ready_pct = 70;
    rel_delay = 0;
    n0 = rsp_count;
    do_cmd(2'd2, 5'd0, 32'd0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (rsp_count - n0 == 9) break;
    end
    #1 rst = 1'b1;
    exp_q.delete(); wq.delete();
    @(negedge clk);
    check("dump_at_idx10", 128'({rf_own, rf_a1}), 128'({1'b1, 5'd10}));
    @(negedge clk);
    check_reset("reset_mid_dump");
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("no_rsp_after_reset", 128'(seen), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
